// File: rtl/multi_port_reg_file.sv
// Multi-port register file: NUM_WR write ports, NUM_RD combinational read ports, hardwired-zero r0,
// and a per-register busy scoreboard. Optional write-to-read forwarding under `REGFILE_BYPASS_EN`.
module multi_port_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        regWriteEn,
    input  logic [NUM_WR*ADDR_W-1:0] regWriteAddr,
    input  logic [NUM_WR*DATA_W-1:0] regWriteData,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy,
    input  logic                     busySetEn,
    input  logic [ADDR_W-1:0]        busySetAddr,
    output logic                     busyAny
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Ascending port order lets the highest-index port overwrite lower ones;
    // the busy set is applied after all clears so a new producer wins.
    always_comb begin : write_next
        logic [ADDR_W-1:0] wa;
        regs_d = regs_q;
        busy_d = busy_q;
        wa     = '0;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            wa = regWriteAddr[k*ADDR_W +: ADDR_W];
            if (regWriteEn[k] && wa != '0) begin
                regs_d[wa] = regWriteData[k*DATA_W +: DATA_W];
                busy_d[wa] = 1'b0;
            end
        end
        if (busySetEn && busySetAddr != '0) begin
            busy_d[busySetAddr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin : read_mux
        logic [ADDR_W-1:0] ra;
        ra     = '0;
        rdData = '0;
        rdBusy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            ra = rdAddr[p*ADDR_W +: ADDR_W];
            rdData[p*DATA_W +: DATA_W] = regs_q[ra];
            rdBusy[p]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (regWriteEn[k] && ra != '0 && regWriteAddr[k*ADDR_W +: ADDR_W] == ra) begin
                    rdData[p*DATA_W +: DATA_W] = regWriteData[k*DATA_W +: DATA_W];
                    rdBusy[p]                  = busySetEn && (busySetAddr == ra);
                end
            end
`endif
        end
    end

    assign busyAny = |busy_q;

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Self-checking bench for multi_port_reg_file: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-based model. Honours `REGFILE_BYPASS_EN`.
module tb_multi_port_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_WR-1:0]        regWriteEn;
    logic [NUM_WR*ADDR_W-1:0] regWriteAddr;
    logic [NUM_WR*DATA_W-1:0] regWriteData;
    logic [NUM_RD*ADDR_W-1:0] rdAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;
    logic                     busySetEn;
    logic [ADDR_W-1:0]        busySetAddr;
    logic                     busyAny;

    multi_port_reg_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .regWriteEn  (regWriteEn),
        .regWriteAddr(regWriteAddr),
        .regWriteData(regWriteData),
        .rdAddr      (rdAddr),
        .rdData      (rdData),
        .rdBusy      (rdBusy),
        .busySetEn   (busySetEn),
        .busySetAddr (busySetAddr),
        .busyAny     (busyAny)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    logic [DATA_W-1:0] m_regs [32];
    logic [31:0]       m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [ADDR_W-1:0] waddr(input int k);
        return regWriteAddr[k*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] wdata(input int k);
        return regWriteData[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ADDR_W-1:0] raddr(input int p);
        return rdAddr[p*ADDR_W +: ADDR_W];
    endfunction

    // Highest-priority port writing address a this cycle, or -1.
    function automatic int writer_for(input logic [ADDR_W-1:0] a);
        for (int k = NUM_WR - 1; k >= 0; k--)
            if (regWriteEn[k] && a != 0 && waddr(k) == a) return k;
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int p);
        logic [ADDR_W-1:0] a;
        int w;
        a = raddr(p);
        w = writer_for(a);
`ifdef REGFILE_BYPASS_EN
        if (w >= 0) return wdata(w);
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int p);
        logic [ADDR_W-1:0] a;
        int w;
        a = raddr(p);
        w = writer_for(a);
`ifdef REGFILE_BYPASS_EN
        if (w >= 0) return busySetEn && busySetAddr == a;
`endif
        return m_busy[a];
    endfunction

    // Reference state update at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                int w;
                w = writer_for(ADDR_W'(i));
                if (w >= 0) begin
                    m_regs[i] = wdata(w);
                    m_busy[i] = 1'b0;
                end
            end
            if (busySetEn && busySetAddr != 0) m_busy[busySetAddr] = 1'b1;
        end
    end

    // Compare process: inputs change just after posedge, outputs sampled at negedge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int p = 0; p < NUM_RD; p++) begin
                chk($sformatf("rdData[%0d] a=%0d", p, raddr(p)), rdData[p*DATA_W +: DATA_W], exp_data(p));
                chk($sformatf("rdBusy[%0d] a=%0d", p, raddr(p)), 32'(rdBusy[p]), 32'(exp_busy(p)));
            end
            chk("busyAny", 32'(busyAny), 32'(|m_busy));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        reset      = 1'b0;
        regWriteEn = '0;
        busySetEn  = 1'b0;
    endtask

    task automatic set_wr(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        regWriteEn[k]                     = 1'b1;
        regWriteAddr[k*ADDR_W +: ADDR_W]  = a;
        regWriteData[k*DATA_W +: DATA_W]  = d;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        rdAddr[p*ADDR_W +: ADDR_W] = a;
    endtask

    logic [DATA_W-1:0] exp_word;

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy       = '0;
        reset        = 1'b1;
        regWriteEn   = '1;
        regWriteAddr = {5'd6, 5'd5};
        regWriteData = {2{32'h55AAAA55}};
        rdAddr       = {5'd6, 5'd5};
        busySetEn    = 1'b1;
        busySetAddr  = 5'd4;

        // Reset overrides writes and busy set
        tick;
        idle;
        check_en = 1'b1;
        #2;
        chk("reset rd0", rdData[31:0], 32'h0);
        chk("reset rd1", rdData[63:32], 32'h0);
        chk("reset busyAny", 32'(busyAny), 32'h0);

        // Sweep 31..1 on port 0, read back next cycle
        for (int a = 31; a >= 1; a--) begin
            set_wr(0, ADDR_W'(a), 32'h55AAAA55 ^ 32'(a));
            set_rd(0, ADDR_W'(a));
            tick;
            idle;
            #2;
            chk($sformatf("sweep r%0d", a), rdData[31:0], 32'h55AAAA55 ^ 32'(a));
        end
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_rd(0, 5'd0);
        tick;
        idle;
        #2;
        chk("r0 stays zero", rdData[31:0], 32'h0);

        // Both ports write r7: port 1 wins
        set_wr(0, 5'd7, 32'h11111111);
        set_wr(1, 5'd7, 32'h22222222);
        set_rd(0, 5'd7);
        tick;
        idle;
        #2;
        chk("r7 priority", rdData[31:0], 32'h22222222);

        // Scoreboard on r9
        set_rd(1, 5'd9);
        busySetEn   = 1'b1;
        busySetAddr = 5'd9;
        tick;
        idle;
        #2;
        chk("r9 busy set", 32'(rdBusy[1]), 32'h1);
        chk("busyAny set", 32'(busyAny), 32'h1);
        set_wr(0, 5'd9, 32'h99);
        tick;
        idle;
        #2;
        chk("r9 busy cleared", 32'(rdBusy[1]), 32'h0);
        set_wr(1, 5'd9, 32'h98);
        busySetEn   = 1'b1;
        busySetAddr = 5'd9;
        tick;
        idle;
        #2;
        chk("r9 set beats clear", 32'(rdBusy[1]), 32'h1);

        // Same-cycle write/read of r3 after a fresh reset
        reset = 1'b1;
        tick;
        idle;
        set_wr(0, 5'd3, 32'hDEADBEEF);
        set_rd(0, 5'd3);
        #2;
`ifdef REGFILE_BYPASS_EN
        exp_word = 32'hDEADBEEF;
`else
        exp_word = 32'h0;
`endif
        chk("r3 same cycle", rdData[31:0], exp_word);
        tick;
        idle;
        #2;
        chk("r3 next cycle", rdData[31:0], 32'hDEADBEEF);

        // Reset mid-traffic with busy bits set
        set_wr(0, 5'd31, 32'hCAFEF00D);
        busySetEn   = 1'b1;
        busySetAddr = 5'd10;
        tick;
        reset = 1'b1;
        set_wr(1, 5'd12, 32'hABCD0123);
        busySetEn   = 1'b1;
        busySetAddr = 5'd13;
        tick;
        idle;
        set_rd(0, 5'd31);
        set_rd(1, 5'd12);
        #2;
        chk("mid reset r31", rdData[31:0], 32'h0);
        chk("mid reset r12", rdData[63:32], 32'h0);
        chk("mid reset busyAny", 32'(busyAny), 32'h0);
        set_wr(1, 5'd12, 32'h12345678);
        tick;
        idle;
        #2;
        chk("resume r12", rdData[63:32], 32'h12345678);

        // Randomized traffic, narrow address range on alternate cycles for collisions
        for (int c = 0; c < 3000; c++) begin
            int hi;
            hi = (c % 2 == 0) ? 3 : 31;
            reset        = ($urandom_range(0, 127) == 0);
            regWriteEn   = NUM_WR'($urandom);
            busySetEn    = $urandom_range(0, 1) == 1;
            busySetAddr  = ADDR_W'($urandom_range(0, hi));
            regWriteData = {$urandom, $urandom};
            for (int k = 0; k < NUM_WR; k++)
                regWriteAddr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, hi));
            for (int p = 0; p < NUM_RD; p++)
                rdAddr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, hi));
            tick;
        end
        idle;
        tick;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
